// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared types and constants for the stream result checker
//
// Contents:
//   state_e     : checker FSM states (IDLE, RUN, DRAIN, DONE)
//   LATENCY_MAX : deepest supported alignment line
//   entry_bits  : packed width of one alignment-line entry for a given word width
package checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LATENCY_MAX = 15;

  // valid + last + expected + mask
  function automatic int entry_bits(input int width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/stream_checker_align_line.sv
// rtl/stream_checker_align_line.sv - LATENCY-deep entry delay line with synchronous clear
//
// Ports:
//   i_clk    : clock
//   i_reset  : synchronous active-high reset, empties the line
//   i_clear  : synchronous clear, empties the line (restart)
//   i_entry  : packed entry entering stage 0
//   o_entry  : entry leaving the line; i_entry itself when LATENCY = 0
module align_line #(
  parameter int ENTRY_W = 18,
  parameter int LATENCY = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic [ENTRY_W-1:0] i_entry,
  output logic [ENTRY_W-1:0] o_entry
);

  // Keep at least one stage so the array is always legal; it is bypassed at LATENCY = 0.
  localparam int DEPTH = (LATENCY == 0) ? 1 : LATENCY;

  logic [ENTRY_W-1:0] stage_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= i_entry;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign o_entry = (LATENCY == 0) ? i_entry : stage_q[DEPTH-1];

endmodule

// File: rtl/stream_checker.sv
// rtl/stream_checker.sv - aligns expected vectors with DUT output and scores them
//
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_start               : pulse, clears results and enters RUN
//   i_exp_valid/_expected/_mask/_exp_last : expected-vector stream (mask 1 = don't care)
//   i_dut_out             : DUT word, LATENCY cycles after its expected word
//   o_busy, o_done, o_pass: status / verdict
//   o_vec_count, o_err_count : saturating counters
//   o_first_err_idx/_got/_exp : first mismatch capture
module stream_checker
  import checker_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_exp_valid,
  input  logic [WIDTH-1:0] i_expected,
  input  logic [WIDTH-1:0] i_mask,
  input  logic             i_exp_last,
  input  logic [WIDTH-1:0] i_dut_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_vec_count,
  output logic [CNT_W-1:0] o_err_count,
  output logic [CNT_W-1:0] o_first_err_idx,
  output logic [WIDTH-1:0] o_first_err_got,
  output logic [WIDTH-1:0] o_first_err_exp
);

  typedef struct packed {
    logic             valid;
    logic             last;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] mask;
  } entry_t;

  localparam int ENTRY_W = entry_bits(WIDTH);
  localparam int LAT_EFF = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;

  state_e state_q, state_d;

  logic [CNT_W-1:0] vec_count_q, err_count_q, first_idx_q;
  logic [WIDTH-1:0] first_got_q, first_exp_q;

  entry_t             line_in, line_out;
  logic [ENTRY_W-1:0] line_out_bits;
  logic               accept, compare, mismatch;

  // A word presented in the i_start cycle is dropped: the restart wins.
  assign accept = (state_q == ST_RUN) && i_exp_valid && !i_start;

  always_comb begin
    line_in          = '0;
    line_in.valid    = accept;
    line_in.last     = i_exp_last;
    line_in.expected = i_expected;
    line_in.mask     = i_mask;
  end

  align_line #(
    .ENTRY_W (ENTRY_W),
    .LATENCY (LAT_EFF)
  ) u_align (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_start),
    .i_entry (line_in),
    .o_entry (line_out_bits)
  );

  assign line_out = entry_t'(line_out_bits);
  assign compare  = line_out.valid && !i_start;
  assign mismatch = |((i_dut_out ^ line_out.expected) & ~line_out.mask);

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept && i_exp_last) state_d = (LAT_EFF == 0) ? ST_DONE : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (compare && line_out.last) state_d = ST_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_start) begin
      vec_count_q <= '0;
      err_count_q <= '0;
      first_idx_q <= '0;
      first_got_q <= '0;
      first_exp_q <= '0;
    end else if (compare) begin
      if (vec_count_q != '1) vec_count_q <= vec_count_q + 1'b1;
      if (mismatch) begin
        if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
        // Error count is still zero only for the first mismatch since start.
        if (err_count_q == '0) begin
          first_idx_q <= vec_count_q;
          first_got_q <= i_dut_out;
          first_exp_q <= line_out.expected;
        end
      end
    end
  end

  assign o_busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_done          = (state_q == ST_DONE);
  assign o_pass          = (state_q == ST_DONE) && (err_count_q == '0);
  assign o_vec_count     = vec_count_q;
  assign o_err_count     = err_count_q;
  assign o_first_err_idx = first_idx_q;
  assign o_first_err_got = first_got_q;
  assign o_first_err_exp = first_exp_q;

endmodule

// File: tb/tb_stream_checker.sv
// tb/tb_stream_checker.sv - directed self-checking bench for stream_checker
module tb_stream_checker;

  logic       clk = 1'b0;
  logic       rst, start, exp_valid, exp_last;
  logic [7:0] expected, mask, dut_out;

  always #5 clk = ~clk;

  logic        busy_l0, done_l0, pass_l0, busy_l1, done_l1, pass_l1;
  logic        busy_l2, done_l2, pass_l2, busy_s, done_s, pass_s;
  logic [15:0] vec_l0, err_l0, idx_l0, vec_l1, err_l1, idx_l1, vec_l2, err_l2, idx_l2;
  logic [7:0]  got_l0, xp_l0, got_l1, xp_l1, got_l2, xp_l2, got_s, xp_s;
  logic [2:0]  vec_s, err_s, idx_s;

  stream_checker #(.WIDTH(8), .LATENCY(0), .CNT_W(16)) u_l0 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_exp_valid(exp_valid),
    .i_expected(expected), .i_mask(mask), .i_exp_last(exp_last), .i_dut_out(dut_out),
    .o_busy(busy_l0), .o_done(done_l0), .o_pass(pass_l0), .o_vec_count(vec_l0),
    .o_err_count(err_l0), .o_first_err_idx(idx_l0), .o_first_err_got(got_l0),
    .o_first_err_exp(xp_l0));

  stream_checker #(.WIDTH(8), .LATENCY(1), .CNT_W(16)) u_l1 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_exp_valid(exp_valid),
    .i_expected(expected), .i_mask(mask), .i_exp_last(exp_last), .i_dut_out(dut_out),
    .o_busy(busy_l1), .o_done(done_l1), .o_pass(pass_l1), .o_vec_count(vec_l1),
    .o_err_count(err_l1), .o_first_err_idx(idx_l1), .o_first_err_got(got_l1),
    .o_first_err_exp(xp_l1));

  stream_checker #(.WIDTH(8), .LATENCY(2), .CNT_W(16)) u_l2 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_exp_valid(exp_valid),
    .i_expected(expected), .i_mask(mask), .i_exp_last(exp_last), .i_dut_out(dut_out),
    .o_busy(busy_l2), .o_done(done_l2), .o_pass(pass_l2), .o_vec_count(vec_l2),
    .o_err_count(err_l2), .o_first_err_idx(idx_l2), .o_first_err_got(got_l2),
    .o_first_err_exp(xp_l2));

  stream_checker #(.WIDTH(8), .LATENCY(1), .CNT_W(3)) u_sat (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_exp_valid(exp_valid),
    .i_expected(expected), .i_mask(mask), .i_exp_last(exp_last), .i_dut_out(dut_out),
    .o_busy(busy_s), .o_done(done_s), .o_pass(pass_s), .o_vec_count(vec_s),
    .o_err_count(err_s), .o_first_err_idx(idx_s), .o_first_err_got(got_s),
    .o_first_err_exp(xp_s));

  int checks = 0;
  int errors = 0;

  logic [7:0] q_exp[$], q_got[$], q_mask[$];
  bit         q_valid[$];
  logic [3:0] snap_busy_c0, snap_done_pre;  // {sat, l2, l1, l0}

  task automatic clear_q();
    q_exp.delete(); q_got.delete(); q_mask.delete(); q_valid.delete();
  endtask

  task automatic push(input logic [7:0] e, input logic [7:0] g, input logic [7:0] m, input bit v);
    q_exp.push_back(e); q_got.push_back(g); q_mask.push_back(m); q_valid.push_back(v);
  endtask

  // Start pulse, then one queue slot per cycle; DUT word for slot c appears in cycle c+lat.
  // Returns at the negedge following the final compare.
  task automatic drive_seq(input int lat);
    int n = q_exp.size();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    snap_busy_c0 = {busy_s, busy_l2, busy_l1, busy_l0};
    for (int c = 0; c < n + lat; c++) begin
      if (c > 0) @(negedge clk);
      if (c == n + lat - 1) snap_done_pre = {done_s, done_l2, done_l1, done_l0};
      if (c < n) begin
        exp_valid = q_valid[c]; expected = q_exp[c]; mask = q_mask[c]; exp_last = (c == n - 1);
      end else begin
        exp_valid = 1'b0; exp_last = 1'b0;
      end
      dut_out = (c >= lat) ? q_got[c - lat] : 8'h00;
    end
    @(negedge clk);
    exp_valid = 1'b0; exp_last = 1'b0; dut_out = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; exp_valid = 1'b0; exp_last = 1'b0;
    expected = 8'h00; mask = 8'h00; dut_out = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy_l1, done_l1, pass_l1} !== 3'b000) begin
      errors++; $display("FAIL reset_status got %b want 000", {busy_l1, done_l1, pass_l1}); end
    checks++; if ({vec_l1, err_l1, idx_l1} !== 48'h0) begin
      errors++; $display("FAIL reset_counters got %h want 0", {vec_l1, err_l1, idx_l1}); end
    checks++; if ({got_l1, xp_l1} !== 16'h0) begin
      errors++; $display("FAIL reset_capture got %h want 0", {got_l1, xp_l1}); end
  endtask

  task automatic test_basic_l1();
    clear_q();
    push(8'h11, 8'h11, 8'h00, 1); push(8'h22, 8'h22, 8'h00, 1);
    push(8'h33, 8'h33, 8'h00, 1); push(8'h44, 8'h44, 8'h00, 1);
    drive_seq(1);
    checks++; if (snap_busy_c0[1] !== 1'b1) begin
      errors++; $display("FAIL basic_busy_after_start got %b want 1", snap_busy_c0[1]); end
    checks++; if (snap_done_pre[1] !== 1'b0) begin
      errors++; $display("FAIL basic_done_early got %b want 0", snap_done_pre[1]); end
    checks++; if ({done_l1, pass_l1, busy_l1} !== 3'b110) begin
      errors++; $display("FAIL basic_status got %b want 110", {done_l1, pass_l1, busy_l1}); end
    checks++; if (vec_l1 !== 16'd4 || err_l1 !== 16'd0) begin
      errors++; $display("FAIL basic_counts got vec=%0d err=%0d want vec=4 err=0", vec_l1, err_l1); end
    @(negedge clk);
    checks++; if (done_l1 !== 1'b1) begin
      errors++; $display("FAIL basic_done_held got %b want 1", done_l1); end
  endtask

  task automatic test_error_l2();
    clear_q();
    push(8'h11, 8'h11, 8'h00, 1); push(8'h22, 8'h22, 8'h00, 1);
    push(8'h33, 8'h3F, 8'h00, 1); push(8'h44, 8'h44, 8'h00, 1);
    drive_seq(2);
    checks++; if ({done_l2, pass_l2} !== 2'b10) begin
      errors++; $display("FAIL err_status got %b want 10", {done_l2, pass_l2}); end
    checks++; if (vec_l2 !== 16'd4 || err_l2 !== 16'd1) begin
      errors++; $display("FAIL err_counts got vec=%0d err=%0d want vec=4 err=1", vec_l2, err_l2); end
    checks++; if (idx_l2 !== 16'd2 || got_l2 !== 8'h3F || xp_l2 !== 8'h33) begin
      errors++; $display("FAIL err_capture got idx=%0d got=%h exp=%h want idx=2 got=3f exp=33", idx_l2, got_l2, xp_l2); end
  endtask

  task automatic test_mask_l1();
    clear_q();
    push(8'h50, 8'h5F, 8'h0F, 1); push(8'hA0, 8'hA1, 8'h0F, 1);
    push(8'hC3, 8'hC0, 8'h0F, 1); push(8'h12, 8'hED, 8'hFF, 1);
    drive_seq(1);
    checks++; if ({done_l1, pass_l1} !== 2'b11 || err_l1 !== 16'd0) begin
      errors++; $display("FAIL mask_pass got done/pass=%b err=%0d want 11 err=0", {done_l1, pass_l1}, err_l1); end
    checks++; if (vec_l1 !== 16'd4) begin
      errors++; $display("FAIL mask_vec got %0d want 4", vec_l1); end
  endtask

  task automatic test_lat0_gaps();
    // Stray valid words before start must be ignored.
    @(negedge clk); exp_valid = 1'b1; exp_last = 1'b1; expected = 8'h99; dut_out = 8'h00;
    @(negedge clk); expected = 8'h98;
    clear_q();
    push(8'hAA, 8'hAA, 8'h00, 1); push(8'h00, 8'h00, 8'h00, 0);
    push(8'hBB, 8'hBB, 8'h00, 1); push(8'h00, 8'h00, 8'h00, 0);
    push(8'h00, 8'h00, 8'h00, 0); push(8'hCC, 8'hCC, 8'h00, 1);
    drive_seq(0);
    checks++; if (vec_l0 !== 16'd3 || err_l0 !== 16'd0) begin
      errors++; $display("FAIL lat0_counts got vec=%0d err=%0d want vec=3 err=0", vec_l0, err_l0); end
    checks++; if (snap_done_pre[0] !== 1'b0) begin
      errors++; $display("FAIL lat0_done_early got %b want 0", snap_done_pre[0]); end
    checks++; if ({done_l0, pass_l0, busy_l0} !== 3'b110) begin
      errors++; $display("FAIL lat0_direct_done got %b want 110", {done_l0, pass_l0, busy_l0}); end
  endtask

  task automatic test_saturate();
    clear_q();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] e;
      e = 8'(i);
      push(e, ~e, 8'h00, 1);
    end
    drive_seq(1);
    checks++; if (vec_s !== 3'd7 || err_s !== 3'd7) begin
      errors++; $display("FAIL sat_counts got vec=%0d err=%0d want vec=7 err=7", vec_s, err_s); end
    checks++; if (idx_s !== 3'd0 || got_s !== 8'hFF || xp_s !== 8'h00) begin
      errors++; $display("FAIL sat_capture got idx=%0d got=%h exp=%h want idx=0 got=ff exp=00", idx_s, got_s, xp_s); end
    checks++; if ({done_s, pass_s} !== 2'b10) begin
      errors++; $display("FAIL sat_status got %b want 10", {done_s, pass_s}); end
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    exp_valid = 1'b1; expected = 8'h11; mask = 8'h00; exp_last = 1'b0; dut_out = 8'h00;
    @(negedge clk); expected = 8'h22; exp_last = 1'b1;
    @(negedge clk); exp_valid = 1'b0; exp_last = 1'b0; dut_out = 8'h11;
    checks++; if (busy_l2 !== 1'b1) begin
      errors++; $display("FAIL drain_busy got %b want 1", busy_l2); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; dut_out = 8'h22;
    repeat (3) @(negedge clk);
    checks++; if ({busy_l2, done_l2, pass_l2} !== 3'b000) begin
      errors++; $display("FAIL abort_status got %b want 000", {busy_l2, done_l2, pass_l2}); end
    checks++; if ({vec_l2, err_l2, idx_l2, got_l2, xp_l2} !== 64'h0) begin
      errors++; $display("FAIL abort_regs got %h want 0", {vec_l2, err_l2, idx_l2, got_l2, xp_l2}); end
    clear_q();
    push(8'h5A, 8'h5A, 8'h00, 1); push(8'hA5, 8'hA5, 8'h00, 1);
    drive_seq(2);
    checks++; if (vec_l2 !== 16'd2 || {done_l2, pass_l2} !== 2'b11) begin
      errors++; $display("FAIL rerun got vec=%0d done/pass=%b want vec=2 11", vec_l2, {done_l2, pass_l2}); end
  endtask

  initial begin
    test_reset();
    test_basic_l1();
    test_error_l2();
    test_mask_l1();
    test_lat0_gaps();
    test_saturate();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
